fetch_sequencer: RTL



---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_queue.sv | 55 +++++
 rtl/fetch_sequencer.sv | 81 ++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;
  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam int PC_W    = 8;
  localparam int INSTR_W = 32;

  typedef enum logic {RUN, FAULT} state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched words; flush beats any same-cycle push/pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             din,
  output fetch_entry_t             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t [DEPTH-1:0] mem;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head is read straight from storage registers, never from the write data.
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC, feeds a small queue to decode, handles redirects and misaligned-target faults.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int              ADDR_W   = 8,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
  parameter int              DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic              fault
);
  state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic push, pop, flush, full, empty;
  logic [$clog2(DEPTH):0] count;
  fetch_entry_t din, head;

  assign imem_addr = pc;
  assign fault     = (state == FAULT);
  assign out_valid = (count != '0);
  assign pop       = !empty && out_ready;
  assign out_instr = DATA_W'(head.instr);
  assign out_pc    = ADDR_W'(head.pc);
  assign din.instr = INSTR_W'(imem_data);
  assign din.pc    = PC_W'(pc);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_n;
      pc    <= pc_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    push    = 1'b0;
    flush   = 1'b0;
    case (state)
      RUN: begin
        if (redir_valid) begin
          flush = 1'b1;
          // Misaligned targets leave the PC alone and park the fetcher.
          if (redir_pc[1:0] == 2'b00) pc_n = redir_pc;
          else                        state_n = FAULT;
        end else begin
          push = !full || pop;
          if (push) pc_n = pc + ADDR_W'(INSTR_BYTES);
        end
      end
      FAULT: ;
      default: state_n = RUN;
    endcase
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
endmodule
